gen_bank_scheduler: RTL and testbench



---
 rtl/gen_bank_scheduler_pkg.sv | 35 +++
 rtl/gen_bank_scheduler_bank_route_mux.sv | 83 ++++++++
 rtl/gen_bank_scheduler.sv | 198 +++++++++++++++++++
 tb/tb_gen_bank_scheduler.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gen_bank_scheduler_pkg.sv
// Shared types and constants for the generation bank scheduler: FSM states,
// bank indices and the phase-to-bank mapping helpers.
package gen_bank_scheduler_pkg;

  localparam int ADDR_W_DEF = 24;
  localparam int DATA_W_DEF = 32;

  localparam logic [1:0] PAIR0_EVO  = 2'd0;
  localparam logic [1:0] PAIR0_DISP = 2'd1;
  localparam logic [1:0] PAIR1_EVO  = 2'd2;
  localparam logic [1:0] PAIR1_DISP = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_READY   = 3'd2,
    ST_EVOLVE  = 3'd3,
    ST_WAIT_VB = 3'd4,
    ST_SWAP    = 3'd5
  } sched_state_e;

  // The source pair is pair 0 in phase 0 and pair 1 in phase 1.
  function automatic logic [1:0] src_evo_bank(input logic phase);
    return phase ? PAIR1_EVO : PAIR0_EVO;
  endfunction

  function automatic logic [1:0] src_disp_bank(input logic phase);
    return phase ? PAIR1_DISP : PAIR0_DISP;
  endfunction

  function automatic logic banks_valid(input sched_state_e st);
    return (st != ST_IDLE) && (st != ST_LOAD);
  endfunction

endpackage

// File: rtl/gen_bank_scheduler_bank_route_mux.sv
// Combinational routing of the loader, round engine and VGA buses onto the
// four generation RAM ports, selected by the scheduler state and phase.
module bank_route_mux
  import gen_bank_scheduler_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  sched_state_e      state_i,
  input  logic              phase_i,
  input  logic              load_init_i,
  input  logic              init_wren_i,
  input  logic [ADDR_W-1:0] init_addr_i,
  input  logic [DATA_W-1:0] init_wdata_i,
  input  logic              preset_wren_i,
  input  logic [ADDR_W-1:0] preset_addr_i,
  input  logic [DATA_W-1:0] preset_wdata_i,
  input  logic [ADDR_W-1:0] round_rd_addr_i,
  input  logic [ADDR_W-1:0] round_wr_addr_i,
  input  logic              round_wren_i,
  input  logic [DATA_W-1:0] round_wdata_i,
  input  logic [ADDR_W-1:0] vga_addr_i,
  output logic [ADDR_W-1:0] ram_addr_o  [4],
  output logic              ram_wren_o  [4],
  output logic              ram_rden_o  [4],
  output logic [DATA_W-1:0] ram_wdata_o [4]
);

  logic              ld_wren_s;
  logic [ADDR_W-1:0] ld_addr_s;
  logic [DATA_W-1:0] ld_wdata_s;

  // Pick the bus of whichever loader currently holds the grant.
  always_comb begin
    if (load_init_i) begin
      ld_wren_s  = init_wren_i;
      ld_addr_s  = init_addr_i;
      ld_wdata_s = init_wdata_i;
    end else begin
      ld_wren_s  = preset_wren_i;
      ld_addr_s  = preset_addr_i;
      ld_wdata_s = preset_wdata_i;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_bank
    localparam logic [1:0] BANK = 2'(g);

    // Per-bank port selection from the registered state and phase.
    always_comb begin
      ram_addr_o[g]  = vga_addr_i;
      ram_wren_o[g]  = 1'b0;
      ram_rden_o[g]  = 1'b1;
      ram_wdata_o[g] = '0;
      case (state_i)
        ST_LOAD: begin
          ram_addr_o[g]  = ld_addr_s;
          ram_wren_o[g]  = ld_wren_s;
          ram_rden_o[g]  = 1'b0;
          ram_wdata_o[g] = ld_wdata_s;
        end
        ST_EVOLVE, ST_WAIT_VB, ST_SWAP: begin
          if (BANK == src_evo_bank(phase_i)) begin
            ram_addr_o[g] = round_rd_addr_i;
          end else if (BANK == src_disp_bank(phase_i)) begin
            ram_addr_o[g] = vga_addr_i;
          end else begin
            // Both destination copies receive the same round writes.
            ram_addr_o[g]  = round_wr_addr_i;
            ram_wren_o[g]  = round_wren_i;
            ram_rden_o[g]  = 1'b0;
            ram_wdata_o[g] = round_wdata_i;
          end
        end
        default: begin
          ram_addr_o[g] = vga_addr_i;
          ram_rden_o[g] = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/gen_bank_scheduler.sv
// Generation bank scheduler: owns the ping-pong phase, arbitrates the loaders,
// launches one round per tick and flips bank pairs only during vertical blank.
module gen_bank_scheduler
  import gen_bank_scheduler_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int GEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_req,
  input  logic              init_done,
  output logic              init_gnt,
  input  logic              init_wren,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [DATA_W-1:0] init_wdata,
  input  logic              preset_req,
  input  logic              preset_done,
  output logic              preset_gnt,
  input  logic              preset_wren,
  input  logic [ADDR_W-1:0] preset_addr,
  input  logic [DATA_W-1:0] preset_wdata,
  input  logic              run_en,
  input  logic              evo_tick,
  output logic              round_start,
  output logic              round_abort,
  input  logic              round_done,
  input  logic [ADDR_W-1:0] round_rd_addr,
  input  logic [ADDR_W-1:0] round_wr_addr,
  input  logic              round_wren,
  input  logic [DATA_W-1:0] round_wdata,
  output logic [DATA_W-1:0] round_rdata,
  input  logic              vblank,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic [DATA_W-1:0] vga_rdata,
  output logic [ADDR_W-1:0] ram_addr  [4],
  output logic              ram_wren  [4],
  output logic              ram_rden  [4],
  output logic [DATA_W-1:0] ram_wdata [4],
  input  logic [DATA_W-1:0] ram_q     [4],
  output logic              phase,
  output logic [GEN_W-1:0]  gen_count,
  output logic              overrun
);

  sched_state_e     state_q, state_d, state_rd_q;
  logic             phase_q, phase_d, phase_rd_q;
  logic [GEN_W-1:0] gen_q, gen_d;
  logic             overrun_q, overrun_d;
  logic             init_gnt_q, init_gnt_d;
  logic             preset_gnt_q, preset_gnt_d;
  logic             start_q, start_d;
  logic             abort_q, abort_d;

  // Next-state, grant and pulse logic; init_req pre-empts every other event.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    gen_d        = gen_q;
    overrun_d    = overrun_q;
    init_gnt_d   = init_gnt_q;
    preset_gnt_d = preset_gnt_q;
    start_d      = 1'b0;
    abort_d      = 1'b0;
    if (init_req && (state_q != ST_LOAD)) begin
      state_d      = ST_LOAD;
      init_gnt_d   = 1'b1;
      preset_gnt_d = 1'b0;
      phase_d      = 1'b0;
      gen_d        = '0;
      overrun_d    = 1'b0;
      abort_d      = (state_q == ST_EVOLVE) || (state_q == ST_WAIT_VB);
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (preset_req) begin
            state_d      = ST_LOAD;
            preset_gnt_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_LOAD: begin
          if ((init_gnt_q && init_done) || (preset_gnt_q && preset_done)) begin
            state_d      = ST_READY;
            init_gnt_d   = 1'b0;
            preset_gnt_d = 1'b0;
          end else begin
            state_d = ST_LOAD;
          end
        end
        ST_READY: begin
          if (preset_req) begin
            state_d      = ST_LOAD;
            preset_gnt_d = 1'b1;
          end else if (run_en && evo_tick) begin
            state_d = ST_EVOLVE;
            start_d = 1'b1;
          end else begin
            state_d = ST_READY;
          end
        end
        ST_EVOLVE: begin
          if (round_done) begin
            state_d = ST_WAIT_VB;
          end else begin
            state_d = ST_EVOLVE;
          end
        end
        ST_WAIT_VB: begin
          if (vblank) begin
            state_d = ST_SWAP;
          end else begin
            state_d = ST_WAIT_VB;
          end
        end
        ST_SWAP: begin
          state_d = ST_READY;
          phase_d = ~phase_q;
          gen_d   = gen_q + {{(GEN_W-1){1'b0}}, 1'b1};
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
      // A tick while a round is still in flight is dropped, not queued.
      if (evo_tick && (state_q inside {ST_EVOLVE, ST_WAIT_VB, ST_SWAP})) begin
        overrun_d = 1'b1;
      end else begin
        overrun_d = overrun_d;
      end
    end
  end

  // State registers plus the one-cycle-delayed read-data select.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      phase_q      <= 1'b0;
      gen_q        <= '0;
      overrun_q    <= 1'b0;
      init_gnt_q   <= 1'b0;
      preset_gnt_q <= 1'b0;
      start_q      <= 1'b0;
      abort_q      <= 1'b0;
      state_rd_q   <= ST_IDLE;
      phase_rd_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      gen_q        <= gen_d;
      overrun_q    <= overrun_d;
      init_gnt_q   <= init_gnt_d;
      preset_gnt_q <= preset_gnt_d;
      start_q      <= start_d;
      abort_q      <= abort_d;
      state_rd_q   <= state_q;
      phase_rd_q   <= phase_q;
    end
  end

  bank_route_mux #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_route (
    .state_i        (state_q),
    .phase_i        (phase_q),
    .load_init_i    (init_gnt_q),
    .init_wren_i    (init_wren),
    .init_addr_i    (init_addr),
    .init_wdata_i   (init_wdata),
    .preset_wren_i  (preset_wren),
    .preset_addr_i  (preset_addr),
    .preset_wdata_i (preset_wdata),
    .round_rd_addr_i(round_rd_addr),
    .round_wr_addr_i(round_wr_addr),
    .round_wren_i   (round_wren),
    .round_wdata_i  (round_wdata),
    .vga_addr_i     (vga_addr),
    .ram_addr_o     (ram_addr),
    .ram_wren_o     (ram_wren),
    .ram_rden_o     (ram_rden),
    .ram_wdata_o    (ram_wdata)
  );

  assign round_rdata = ram_q[src_evo_bank(phase_rd_q)];
  assign vga_rdata   = banks_valid(state_rd_q) ? ram_q[src_disp_bank(phase_rd_q)] : '0;

  assign init_gnt    = init_gnt_q;
  assign preset_gnt  = preset_gnt_q;
  assign round_start = start_q;
  assign round_abort = abort_q;
  assign phase       = phase_q;
  assign gen_count   = gen_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_gen_bank_scheduler.sv
// Self-checking bench: directed test-plan sequence followed by random traffic,
// all compared each cycle against a behavioural model with its own RAM model.
module tb_gen_bank_scheduler;
  localparam int AW = 24;
  localparam int DW = 32;
  localparam int GW = 16;

  logic clk;
  logic rst;
  logic init_req, init_done, init_gnt, init_wren;
  logic [AW-1:0] init_addr;
  logic [DW-1:0] init_wdata;
  logic preset_req, preset_done, preset_gnt, preset_wren;
  logic [AW-1:0] preset_addr;
  logic [DW-1:0] preset_wdata;
  logic run_en, evo_tick, round_start, round_abort, round_done, round_wren;
  logic [AW-1:0] round_rd_addr, round_wr_addr;
  logic [DW-1:0] round_wdata, round_rdata;
  logic vblank;
  logic [AW-1:0] vga_addr;
  logic [DW-1:0] vga_rdata;
  logic [AW-1:0] ram_addr [4];
  logic          ram_wren [4];
  logic          ram_rden [4];
  logic [DW-1:0] ram_wdata[4];
  logic [DW-1:0] ram_q    [4];
  logic          phase;
  logic [GW-1:0] gen_count;
  logic          overrun;

  int n_checks = 0;
  int n_fail   = 0;

  gen_bank_scheduler #(.ADDR_W(AW), .DATA_W(DW), .GEN_W(GW)) dut (
    .clk(clk), .rst(rst),
    .init_req(init_req), .init_done(init_done), .init_gnt(init_gnt),
    .init_wren(init_wren), .init_addr(init_addr), .init_wdata(init_wdata),
    .preset_req(preset_req), .preset_done(preset_done), .preset_gnt(preset_gnt),
    .preset_wren(preset_wren), .preset_addr(preset_addr), .preset_wdata(preset_wdata),
    .run_en(run_en), .evo_tick(evo_tick),
    .round_start(round_start), .round_abort(round_abort), .round_done(round_done),
    .round_rd_addr(round_rd_addr), .round_wr_addr(round_wr_addr),
    .round_wren(round_wren), .round_wdata(round_wdata), .round_rdata(round_rdata),
    .vblank(vblank), .vga_addr(vga_addr), .vga_rdata(vga_rdata),
    .ram_addr(ram_addr), .ram_wren(ram_wren), .ram_rden(ram_rden),
    .ram_wdata(ram_wdata), .ram_q(ram_q),
    .phase(phase), .gen_count(gen_count), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: "loading", "banks valid" and a round step
  // (0 none, 1 computing, 2 finished awaiting blank, 3 flipping).
  bit m_known = 1'b0, m_load = 1'b0, m_own_init = 1'b0, m_valid = 1'b0;
  bit m_start = 1'b0, m_abort = 1'b0, m_ovr = 1'b0, m_phase = 1'b0;
  bit rd_gate = 1'b0, rd_phase = 1'b0;
  int m_step = 0, m_gen = 0;

  logic [DW-1:0] mem [4][32];
  logic [DW-1:0] eq  [4];
  logic [DW-1:0] cp_rq [4], cx_rq [4];
  bit            cp_rden [4], cx_rden [4];

  logic [AW-1:0] xp_addr [4];
  logic [DW-1:0] xp_wdata[4];
  bit            xp_wren [4], xp_rden [4], xp_wchk [4];

  // Expected RAM port usage derived from who owns which bank right now.
  always_comb begin
    for (int b = 0; b < 4; b++) begin
      xp_addr[b] = vga_addr; xp_wdata[b] = '0;
      xp_wren[b] = 1'b0; xp_rden[b] = 1'b1; xp_wchk[b] = 1'b0;
      if (m_load) begin
        xp_addr[b]  = m_own_init ? init_addr : preset_addr;
        xp_wren[b]  = m_own_init ? init_wren : preset_wren;
        xp_wdata[b] = m_own_init ? init_wdata : preset_wdata;
        xp_rden[b]  = 1'b0; xp_wchk[b] = 1'b1;
      end else if (m_step != 0) begin
        if ((b / 2) == int'(m_phase)) begin
          xp_addr[b] = (b % 2 == 1) ? vga_addr : round_rd_addr;
        end else begin
          xp_addr[b] = round_wr_addr; xp_wren[b] = round_wren;
          xp_wdata[b] = round_wdata; xp_rden[b] = 1'b0; xp_wchk[b] = 1'b1;
        end
      end
    end
  end

  task automatic model_step();
    for (int b = 0; b < 4; b++) begin
      if (cp_rden[b]) ram_q[b] = cp_rq[b];
      if (cx_rden[b]) eq[b] = cx_rq[b];
    end
    m_start = 1'b0; m_abort = 1'b0;
    rd_gate = m_valid && !m_load; rd_phase = m_phase;
    if (rst) begin
      m_known = 1'b1; m_load = 1'b0; m_valid = 1'b0; m_step = 0;
      m_phase = 1'b0; m_gen = 0; m_ovr = 1'b0; rd_gate = 1'b0; rd_phase = 1'b0;
    end else if (init_req && !m_load) begin
      m_abort = (m_step == 1) || (m_step == 2);
      m_load = 1'b1; m_own_init = 1'b1; m_step = 0;
      m_phase = 1'b0; m_gen = 0; m_ovr = 1'b0;
    end else if (m_load) begin
      if (m_own_init ? init_done : preset_done) begin
        m_load = 1'b0; m_valid = 1'b1;
      end
    end else if (m_step == 0) begin
      if (preset_req) begin
        m_load = 1'b1; m_own_init = 1'b0;
      end else if (m_valid && run_en && evo_tick) begin
        m_start = 1'b1; m_step = 1;
      end
    end else begin
      if (evo_tick) m_ovr = 1'b1;
      if (m_step == 1 && round_done) m_step = 2;
      else if (m_step == 2 && vblank) m_step = 3;
      else if (m_step == 3) begin
        m_step = 0; m_phase = !m_phase; m_gen = (m_gen + 1) % (1 << GW);
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic compare();
    if (m_known) begin
      for (int b = 0; b < 4; b++) begin
        chk($sformatf("ram_addr[%0d]", b), 32'(ram_addr[b]), 32'(xp_addr[b]));
        chk($sformatf("ram_wren[%0d]", b), 32'(ram_wren[b]), 32'(xp_wren[b]));
        chk($sformatf("ram_rden[%0d]", b), 32'(ram_rden[b]), 32'(xp_rden[b]));
        if (xp_wchk[b]) chk($sformatf("ram_wdata[%0d]", b), ram_wdata[b], xp_wdata[b]);
      end
      chk("init_gnt", 32'(init_gnt), 32'(m_load && m_own_init));
      chk("preset_gnt", 32'(preset_gnt), 32'(m_load && !m_own_init));
      chk("round_start", 32'(round_start), 32'(m_start));
      chk("round_abort", 32'(round_abort), 32'(m_abort));
      chk("phase", 32'(phase), 32'(m_phase));
      chk("gen_count", 32'(gen_count), m_gen);
      chk("overrun", 32'(overrun), 32'(m_ovr));
      chk("round_rdata", round_rdata, eq[2 * int'(rd_phase)]);
      chk("vga_rdata", vga_rdata, rd_gate ? eq[2 * int'(rd_phase) + 1] : 32'h0);
    end
  endtask

  // RAM behaviour: capture reads (real and expected) and apply writes late in
  // the low clock phase, once the stimulus for this cycle is stable.
  task automatic capture();
    for (int b = 0; b < 4; b++) begin
      cp_rden[b] = ram_rden[b]; cp_rq[b] = mem[b][ram_addr[b][4:0]];
      cx_rden[b] = xp_rden[b];  cx_rq[b] = mem[b][xp_addr[b][4:0]];
      if (ram_wren[b]) mem[b][ram_addr[b][4:0]] = ram_wdata[b];
    end
  endtask

  initial begin
    for (int b = 0; b < 4; b++) begin
      ram_q[b] = '0; eq[b] = '0; cp_rden[b] = 1'b0; cx_rden[b] = 1'b0;
      cp_rq[b] = '0; cx_rq[b] = '0;
      for (int a = 0; a < 32; a++) mem[b][a] = '0;
    end
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      #1 compare();
      #3 capture();
    end
  end

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
    #2;
  endtask

  task automatic quiet();
    init_req = 1'b0; init_done = 1'b0; init_wren = 1'b0; init_addr = '0; init_wdata = '0;
    preset_req = 1'b0; preset_done = 1'b0; preset_wren = 1'b0; preset_addr = '0; preset_wdata = '0;
    evo_tick = 1'b0; round_done = 1'b0; round_wren = 1'b0;
    round_rd_addr = '0; round_wr_addr = '0; round_wdata = '0;
  endtask

  task automatic full_round();
    evo_tick = 1'b1; cycle(); evo_tick = 1'b0;
    round_done = 1'b1; cycle(); round_done = 1'b0;
    vblank = 1'b1; cycle(); cycle();
  endtask

  initial begin
    rst = 1'b1; run_en = 1'b0; vblank = 1'b0; vga_addr = '0;
    quiet();
    cycle(); cycle();
    chk("reset phase", 32'(phase), 32'h0);
    chk("reset gen_count", 32'(gen_count), 32'h0);
    chk("reset init_gnt", 32'(init_gnt), 32'h0);
    chk("reset ram_wren", {28'h0, ram_wren[3], ram_wren[2], ram_wren[1], ram_wren[0]}, 32'h0);
    rst = 1'b0;
    cycle();

    // Initial load of 0xA5A5A5A5 at word 0x10 into every bank.
    init_req = 1'b1; cycle(); init_req = 1'b0;
    chk("init_gnt after req", 32'(init_gnt), 32'h1);
    for (int i = 0; i < 4; i++) begin
      init_wren = 1'b1; init_addr = 24'h10; init_wdata = 32'hA5A5_A5A5;
      #1;
      chk("init write enables", {28'h0, ram_wren[3], ram_wren[2], ram_wren[1], ram_wren[0]}, 32'hF);
      chk("init write addr b3", 32'(ram_addr[3]), 32'h10);
      cycle();
    end
    init_wren = 1'b0; init_done = 1'b1; cycle(); init_done = 1'b0;
    chk("init_gnt dropped", 32'(init_gnt), 32'h0);
    vga_addr = 24'h10; cycle(); cycle();
    chk("vga_rdata after load", vga_rdata, 32'hA5A5_A5A5);

    // Phase-0 round: writes to banks 2/3, reads from bank 0.
    run_en = 1'b1; evo_tick = 1'b1; cycle(); evo_tick = 1'b0;
    chk("round_start pulse", 32'(round_start), 32'h1);
    round_wren = 1'b1; round_wr_addr = 24'h3; round_rd_addr = 24'h10; round_wdata = 32'h1234_5678;
    #1;
    chk("phase0 write banks", {28'h0, ram_wren[3], ram_wren[2], ram_wren[1], ram_wren[0]}, 32'hC);
    chk("phase0 read addr b0", 32'(ram_addr[0]), 32'h10);
    cycle();
    chk("round_start one cycle", 32'(round_start), 32'h0);
    round_wren = 1'b0; round_done = 1'b1; cycle(); round_done = 1'b0;
    repeat (100) cycle();
    chk("no swap without vblank", 32'(phase), 32'h0);
    vblank = 1'b1; cycle(); cycle();
    chk("phase after swap 1", 32'(phase), 32'h1);
    chk("gen after swap 1", 32'(gen_count), 32'h1);

    // Phase-1 round with a lost tick, vblank already high at round end.
    evo_tick = 1'b1; cycle(); evo_tick = 1'b0;
    round_wren = 1'b1; vga_addr = 24'h7;
    #1;
    chk("phase1 write banks", {28'h0, ram_wren[3], ram_wren[2], ram_wren[1], ram_wren[0]}, 32'h3);
    chk("phase1 vga addr b3", 32'(ram_addr[3]), 32'h7);
    evo_tick = 1'b1; cycle(); evo_tick = 1'b0; round_wren = 1'b0;
    chk("overrun set", 32'(overrun), 32'h1);
    chk("no second start", 32'(round_start), 32'h0);
    round_done = 1'b1; cycle(); round_done = 1'b0; cycle(); cycle();
    chk("phase after swap 2", 32'(phase), 32'h0);
    chk("gen after swap 2", 32'(gen_count), 32'h2);

    // Third round to phase 1, then abort the fourth from WAIT_VB.
    full_round();
    chk("gen after swap 3", 32'(gen_count), 32'h3);
    vblank = 1'b0; evo_tick = 1'b1; cycle(); evo_tick = 1'b0;
    round_done = 1'b1; cycle(); round_done = 1'b0;
    init_req = 1'b1; vblank = 1'b1; cycle(); init_req = 1'b0;
    chk("abort pulse", 32'(round_abort), 32'h1);
    chk("abort init_gnt", 32'(init_gnt), 32'h1);
    chk("abort phase", 32'(phase), 32'h0);
    chk("abort gen", 32'(gen_count), 32'h0);
    chk("abort overrun", 32'(overrun), 32'h0);
    cycle();
    chk("no swap after abort", 32'(gen_count), 32'h0);

    // init beats preset; a preset_done during an init load is ignored.
    init_done = 1'b1; cycle(); init_done = 1'b0;
    preset_req = 1'b1; init_req = 1'b1; cycle(); preset_req = 1'b0; init_req = 1'b0;
    chk("tie init_gnt", 32'(init_gnt), 32'h1);
    chk("tie preset_gnt", 32'(preset_gnt), 32'h0);
    preset_done = 1'b1; cycle(); preset_done = 1'b0;
    chk("stray preset_done", 32'(init_gnt), 32'h1);
    init_done = 1'b1; cycle(); init_done = 1'b0;

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 799) == 0);
      init_req = ($urandom_range(0, 149) == 0);
      preset_req = ($urandom_range(0, 59) == 0);
      init_done = ($urandom_range(0, 11) == 0);
      preset_done = ($urandom_range(0, 11) == 0);
      evo_tick = ($urandom_range(0, 9) == 0);
      round_done = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 99) == 0) run_en = ~run_en;
      if ($urandom_range(0, 19) == 0) vblank = ~vblank;
      init_wren = 1'($urandom_range(0, 1)); preset_wren = 1'($urandom_range(0, 1));
      round_wren = 1'($urandom_range(0, 1));
      init_addr = 24'($urandom_range(0, 31)); preset_addr = 24'($urandom_range(0, 31));
      round_rd_addr = 24'($urandom_range(0, 31)); round_wr_addr = 24'($urandom_range(0, 31));
      vga_addr = 24'($urandom_range(0, 31));
      init_wdata = $urandom; preset_wdata = $urandom; round_wdata = $urandom;
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
